// File: rtl/ext_mem_loader.sv
// ext_mem_loader: loads imem/dmem images from a stream, runs the core, then dumps dmem.
module ext_mem_loader #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic [10:0] imem_len,
  input  logic [10:0] dmem_len,
  input  logic [10:0] dump_len,
  input  logic [31:0] run_cycles,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [31:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [31:0] wdata_ext_2,
  input  logic [31:0] rdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE} state_t;
  state_t r_state, w_next, w_first, w_after_i, w_after_d, w_after_r;
  logic [10:0] r_ilen, r_dlen, r_plen, r_idx, w_ilen, w_dlen, w_plen, w_len;
  logic [31:0] r_cnt, r_addr, r_wdata, r_addr2, r_wdata2, r_out, w_addr;
  logic        r_wen, r_wen2, w_start, w_load, w_hs, w_adv, w_last, w_unused;
  assign w_unused  = ^rdata_ext;
  assign w_ilen    = imem_len > 11'(IMEM_WORDS) ? 11'(IMEM_WORDS) : imem_len;
  assign w_dlen    = dmem_len > 11'(DMEM_WORDS) ? 11'(DMEM_WORDS) : dmem_len;
  assign w_plen    = dump_len > 11'(DMEM_WORDS) ? 11'(DMEM_WORDS) : dump_len;
  assign w_start   = start && (r_state == IDLE || r_state == DONE);
  assign w_load    = r_state == LOAD_I || r_state == LOAD_D;
  assign w_hs      = w_load && in_valid;
  assign w_adv     = w_hs || (r_state == DUMP_OUT && out_ready);
  assign w_len     = r_state == LOAD_I ? r_ilen : r_state == LOAD_D ? r_dlen : r_plen;
  assign w_last    = r_idx + 11'd1 == w_len;
  assign w_addr    = {19'd0, r_idx, 2'b00};
  assign w_after_r = r_plen != '0 ? DUMP_RD : DONE;
  assign w_after_d = r_cnt != '0 ? RUN : w_after_r;
  assign w_after_i = r_dlen != '0 ? LOAD_D : w_after_d;
  assign w_first   = w_ilen != '0 ? LOAD_I : w_dlen != '0 ? LOAD_D :
                     run_cycles != '0 ? RUN : w_plen != '0 ? DUMP_RD : DONE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = start ? w_first : r_state;
      LOAD_I:     w_next = w_hs && w_last ? w_after_i : r_state;
      LOAD_D:     w_next = w_hs && w_last ? w_after_d : r_state;
      RUN:        w_next = r_cnt == 32'd1 ? w_after_r : r_state;
      // a trailing dmem write from LOAD_D owns the port for one cycle
      DUMP_RD:    w_next = r_wen2 ? DUMP_RD : DUMP_CAP;
      DUMP_CAP:   w_next = DUMP_OUT;
      DUMP_OUT:   w_next = out_ready ? (w_last ? DONE : DUMP_RD) : r_state;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state  <= IDLE;
      r_ilen   <= '0;
      r_dlen   <= '0;
      r_plen   <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_wen    <= 1'b0;
      r_wen2   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_addr2  <= '0;
      r_wdata2 <= '0;
      r_out    <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_ilen <= w_ilen;
        r_dlen <= w_dlen;
        r_plen <= w_plen;
        r_cnt  <= run_cycles;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt - 32'd1;
      end
      r_idx  <= (w_start || (w_adv && w_last)) ? '0 : w_adv ? r_idx + 11'd1 : r_idx;
      r_wen  <= w_hs && r_state == LOAD_I;
      r_wen2 <= w_hs && r_state == LOAD_D;
      if (w_hs && r_state == LOAD_I) begin
        r_addr  <= w_addr;
        r_wdata <= in_data;
      end
      if (w_hs && r_state == LOAD_D) begin
        r_addr2  <= w_addr;
        r_wdata2 <= in_data;
      end
      if (r_state == DUMP_CAP) r_out <= rdata_ext_2;
    end
  end
  assign in_ready    = w_load;
  assign out_valid   = r_state == DUMP_OUT;
  assign out_data    = r_out;
  assign addr_ext    = r_addr;
  assign wen_ext     = r_wen;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = r_wdata;
  assign addr_ext_2  = r_state == DUMP_RD ? w_addr : r_addr2;
  assign wen_ext_2   = r_wen2;
  assign ren_ext_2   = r_state == DUMP_RD && !r_wen2;
  assign wdata_ext_2 = r_wdata2;
  assign cpu_enable  = r_state == RUN;
  assign busy        = r_state != IDLE && r_state != DONE;
  assign done        = r_state == DONE;
endmodule

// File: tb/tb_ext_mem_loader.sv
// tb_ext_mem_loader: randomized scenario bench with a stream-level reference model.
module tb_ext_mem_loader;
  typedef logic [31:0] wq_t[$];
  logic clk = 1'b0, arst, start;
  logic [10:0] imem_len, dmem_len, dump_len;
  logic [31:0] run_cycles, in_data, out_data, addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] rdata_ext, rdata_ext_2;
  logic in_valid, in_ready, out_valid, out_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic cpu_enable, busy, done;
  logic [168:0] all_o;
  int tests = 0, fails = 0;
  logic [31:0] mem_d [1024];
  logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$];
  int en_cnt = 0, ren_cnt = 0;

  ext_mem_loader dut (
    .clk(clk), .arst(arst), .start(start), .imem_len(imem_len), .dmem_len(dmem_len),
    .dump_len(dump_len), .run_cycles(run_cycles), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .rdata_ext(rdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .cpu_enable(cpu_enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign rdata_ext = 32'd0;
  assign all_o = {in_ready, out_valid, out_data, addr_ext, wen_ext, ren_ext, wdata_ext,
                  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, cpu_enable, busy, done};

  always @(posedge clk) begin
    if (ren_ext_2) rdata_ext_2 <= mem_d[addr_ext_2[11:2]];
    if (wen_ext_2) mem_d[addr_ext_2[11:2]] <= wdata_ext_2;
  end

  always @(negedge clk) begin
    if (wen_ext) begin iw_a.push_back(addr_ext); iw_d.push_back(wdata_ext); end
    if (wen_ext_2) begin dw_a.push_back(addr_ext_2); dw_d.push_back(wdata_ext_2); end
    en_cnt  <= en_cnt + int'(cpu_enable);
    ren_cnt <= ren_cnt + int'(ren_ext) + int'(ren_ext_2);
  end

  task automatic run_seq(input string nm, input int il, input int dl, input int pl,
                         input logic [31:0] rc, input int vpct, input int rpct,
                         input bit poke, input wq_t fixed);
    wq_t s, outs;
    int ic, dc, pc, p, cyc, last_hs, i0, d0, e0;
    bit stall, poked;
    logic [31:0] held;
    ic = il > 512 ? 512 : il;
    dc = dl > 1024 ? 1024 : dl;
    pc = pl > 1024 ? 1024 : pl;
    s = fixed;
    while (s.size() < ic + dc) s.push_back($urandom);
    i0 = iw_a.size(); d0 = dw_a.size(); e0 = en_cnt;
    p = 0; cyc = 0; last_hs = -1; stall = 0; poked = 0; held = '0;
    @(posedge clk); #1;
    imem_len = 11'(il); dmem_len = 11'(dl); dump_len = 11'(pl); run_cycles = rc;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && cyc < 5000) begin
      in_valid = p < s.size() && (vpct < 0 ? cyc % 2 == 0 : $urandom_range(99) < vpct);
      in_data = in_valid ? s[p] : $urandom;
      out_ready = rpct < 0 ? cyc % 5 == 4 : $urandom_range(99) < rpct;
      start = poke && !poked && cpu_enable;
      if (start) poked = 1;
      @(negedge clk);
      if (stall) begin
        tests++;
        if (!out_valid || out_data !== held) begin
          fails++;
          $display("FAIL %s stall_hold: valid=%0b data=%h required valid=1 data=%h", nm, out_valid, out_data, held);
        end
      end
      stall = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) p++;
      if (out_valid && out_ready) begin
        outs.push_back(out_data);
        if (rpct == 100 && last_hs >= 0) begin
          tests++;
          if (cyc - last_hs != 3) begin
            fails++;
            $display("FAIL %s dump_rate: %0d cycles/word required 3", nm, cyc - last_hs);
          end
        end
        last_hs = cyc;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (!done) begin fails++; $display("FAIL %s done: got 0 required 1 (timeout %0d cycles)", nm, cyc); end
    tests++;
    if (iw_a.size() - i0 != ic) begin fails++; $display("FAIL %s imem_count: got %0d required %0d", nm, iw_a.size() - i0, ic); end
    for (int k = 0; k < ic && i0 + k < iw_a.size(); k++) begin
      tests++;
      if (iw_a[i0+k] !== 32'(k*4) || iw_d[i0+k] !== s[k]) begin
        fails++;
        $display("FAIL %s imem_wr[%0d]: got %h/%h required %h/%h", nm, k, iw_a[i0+k], iw_d[i0+k], 32'(k*4), s[k]);
      end
    end
    tests++;
    if (dw_a.size() - d0 != dc) begin fails++; $display("FAIL %s dmem_count: got %0d required %0d", nm, dw_a.size() - d0, dc); end
    for (int k = 0; k < dc && d0 + k < dw_a.size(); k++) begin
      tests++;
      if (dw_a[d0+k] !== 32'(k*4) || dw_d[d0+k] !== s[ic+k]) begin
        fails++;
        $display("FAIL %s dmem_wr[%0d]: got %h/%h required %h/%h", nm, k, dw_a[d0+k], dw_d[d0+k], 32'(k*4), s[ic+k]);
      end
    end
    tests++;
    if (en_cnt - e0 != int'(rc)) begin fails++; $display("FAIL %s enable_cycles: got %0d required %0d", nm, en_cnt - e0, rc); end
    tests++;
    if (outs.size() != pc) begin fails++; $display("FAIL %s dump_count: got %0d required %0d", nm, outs.size(), pc); end
    for (int k = 0; k < pc && k < outs.size(); k++) begin
      tests++;
      if (outs[k] !== s[ic+k]) begin fails++; $display("FAIL %s dump[%0d]: got %h required %h", nm, k, outs[k], s[ic+k]); end
    end
  endtask

  task automatic test_reset;
    arst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    imem_len = '0; dmem_len = '0; dump_len = '0; run_cycles = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (all_o !== '0) begin fails++; $display("FAIL reset_outputs: got %h required 0", all_o); end
    arst = 1'b0;
    @(negedge clk);
    tests++;
    if (all_o !== '0) begin fails++; $display("FAIL reset_idle: got %h required 0", all_o); end
  endtask

  task automatic test_full;
    wq_t f;
    f = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'h11, 32'h22};
    run_seq("full", 3, 2, 2, 32'd5, 100, 100, 0, f);
  endtask

  task automatic test_backpressure;
    wq_t f;
    run_seq("backpressure", 4, 4, 4, 32'd2, -1, -1, 0, f);
  endtask

  task automatic test_zero;
    int i0, d0, r0;
    i0 = iw_a.size(); d0 = dw_a.size(); r0 = ren_cnt;
    @(posedge clk); #1;
    imem_len = '0; dmem_len = '0; dump_len = '0; run_cycles = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL zero_done: done=%0b busy=%0b required 1/0", done, busy); end
    repeat (3) @(negedge clk);
    tests++;
    if (iw_a.size() != i0 || dw_a.size() != d0 || ren_cnt != r0) begin
      fails++;
      $display("FAIL zero_no_access: writes %0d/%0d reads %0d required 0", iw_a.size() - i0, dw_a.size() - d0, ren_cnt - r0);
    end
  endtask

  task automatic test_clamp;
    wq_t f;
    run_seq("clamp", 600, 3, 3, 32'd1, 100, 100, 0, f);
    tests++;
    if (iw_a[iw_a.size()-1] !== 32'h7FC) begin fails++; $display("FAIL clamp_last_addr: got %h required 7fc", iw_a[iw_a.size()-1]); end
  endtask

  task automatic test_reset_mid;
    wq_t s, f;
    int p, d0, i1, d1, e1, cyc;
    for (int k = 0; k < 13; k++) s.push_back($urandom);
    d0 = dw_a.size(); p = 0; cyc = 0;
    @(posedge clk); #1;
    imem_len = 11'd3; dmem_len = 11'd10; dump_len = 11'd2; run_cycles = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (dw_a.size() - d0 < 5 && cyc < 200) begin
      in_valid = 1'b1; in_data = s[p];
      @(negedge clk);
      if (in_ready) p++;
      if (dw_a.size() - d0 >= 5) break;
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (dw_a.size() - d0 < 5) begin fails++; $display("FAIL rstmid_reach: got %0d writes required 5", dw_a.size() - d0); end
    arst = 1'b1;
    #1;
    in_valid = 1'b0;
    tests++;
    if (all_o !== '0) begin fails++; $display("FAIL rstmid_outputs: got %h required 0", all_o); end
    i1 = iw_a.size(); d1 = dw_a.size(); e1 = en_cnt;
    repeat (3) @(negedge clk);
    tests++;
    if (iw_a.size() != i1 || dw_a.size() != d1 || en_cnt != e1 || busy) begin
      fails++;
      $display("FAIL rstmid_quiet: new writes %0d/%0d enables %0d busy %0b required 0", iw_a.size() - i1, dw_a.size() - d1, en_cnt - e1, busy);
    end
    @(posedge clk); #1;
    arst = 1'b0;
    run_seq("after_reset", 3, 3, 2, 32'd2, 100, 100, 0, f);
  endtask

  task automatic test_start_busy;
    wq_t f;
    run_seq("start_busy", 2, 3, 3, 32'd6, 100, 100, 1, f);
  endtask

  task automatic test_random;
    wq_t f;
    int dl;
    for (int n = 0; n < 8; n++) begin
      dl = $urandom_range(20);
      run_seq($sformatf("rand%0d", n), $urandom_range(20), dl, $urandom_range(dl),
              32'($urandom_range(10)), $urandom_range(30, 100), $urandom_range(30, 100), 0, f);
    end
  endtask

  initial begin
    test_reset;
    test_full;
    test_backpressure;
    test_zero;
    test_clamp;
    test_reset_mid;
    test_start_busy;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
